// File: rtl/alu_op_issuer.sv
// alu_op_issuer: holds registered operands on operations_alu for ALU_LAT cycles, then returns the result (optional macro ALU_ISSUER_DIVZERO_CHECK_EN).
module alu_op_issuer #(
  parameter int N = 32,
  parameter int ALU_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_opcode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_operandA,
  output logic [N-1:0] alu_operandB,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carryout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_carry,
  output logic         out_err,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic car_q, car_d, err_q, err_d;
  logic acc, dz;
  assign in_ready = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
  assign acc = in_valid && in_ready;
`ifdef ALU_ISSUER_DIVZERO_CHECK_EN
  assign dz = in_opcode == 3'b011 && in_b == '0;
`else
  assign dz = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    car_d = car_q;
    err_d = err_q;
    if (state_q == SETTLE) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        res_d = alu_result;
        car_d = alu_carryout;
        err_d = 1'b0;
        state_d = DONE;
      end
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
    // A DONE-state accept overrides the return to IDLE, removing the bubble.
    if (acc) begin
      op_d = in_opcode;
      a_d = in_a;
      b_d = in_b;
      cnt_d = 4'(ALU_LAT);
      state_d = dz ? DONE : SETTLE;
      if (dz) begin
        res_d = '0;
        car_d = 1'b0;
        err_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      car_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      car_q <= car_d;
      err_q <= err_d;
    end
  end
  assign alu_opcode = op_q;
  assign alu_operandA = a_q;
  assign alu_operandB = b_q;
  assign out_result = res_q;
  assign out_carry = car_q;
  assign out_err = err_q;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Sequential initiator for the combinational `operations_alu`. It accepts operations from upstream over a valid/ready handshake and registers the opcode and operands onto the ALU inputs. Those inputs are held stable for a fixed number of cycles so that long mul/mod paths can be constrained as multicycle paths. It then captures the result and carry and returns them downstream over a second valid/ready handshake.

## Interface
- `N`, 32, datapath width; must match the ALU instance.
- `ALU_LAT`, 2, number of cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  **reset: synchronous, active-high**.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  block can accept an operation.
- `in_opcode`  in  3  ALU opcode, same encoding as the ALU:
  - 000 add, 001 sub, 010 mul, 011 mod
  - 100 and, 101 concat, 110 srl, 111 sll
- `in_a`, `in_b`  in  N  operands.
- `alu_opcode`  out  3  registered opcode driven to the ALU.
- `alu_operandA`, `alu_operandB`  out  N  registered operands driven to the ALU.
- `alu_result`  in  N  ALU result.
- `alu_carryout`  in  1  ALU carry.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  N  captured result.
- `out_carry`  out  1  captured carry.
- `out_err`  out  1  error flag; see Configuration.
- `busy`  out  1  high in SETTLE or DONE.

## Operation
- FSM states: IDLE, SETTLE, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: load `alu_*` registers from `in_*`, load the latency counter with `ALU_LAT`, go to SETTLE.
- **SETTLE:**
  - `in_ready`=0; the counter decrements each cycle.
  - At the edge where the counter equals 1: capture `alu_result` into `out_result` and `alu_carryout` into `out_carry`, set `out_valid`, go to DONE.
- **DONE:**
  - `out_valid`=1; `out_result`, `out_carry` and `out_err` are held stable until the handshake.
  - `in_ready` = `out_ready` (combinational).
  - On `out_ready`: if `in_valid` is also high, accept the new op in the same edge and go to SETTLE; otherwise clear `out_valid` and go to IDLE.
- `alu_*` registers hold their last value at all times when not loading; they never change during SETTLE.
- No arithmetic is performed in this block; results are passed through exactly at width N.
- Only add produces a nonzero `out_carry`.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after.
  - `out_valid`, `out_result`, `out_carry`, `out_err`, `busy` = 0.
  - `alu_opcode`, `alu_operandA`, `alu_operandB` = 0.
- Latency: accept at edge k gives operands on the ALU from edge k and the result sampled at edge k+`ALU_LAT`, so `out_valid` is high from cycle k+`ALU_LAT`.
- Throughput: one op per `ALU_LAT`+1 cycles with `out_ready` tied high (the same-edge accept in DONE removes the IDLE bubble).
- `rst` asserted in any state takes effect at that edge: any in-flight op is dropped and no `out_valid` pulse appears.
- Upstream fields are sampled only at the accept edge; changes at other times are ignored.

## Configuration
- Macro: `ALU_ISSUER_DIVZERO_CHECK_EN`.
- **Defined:** an accepted op with opcode 011 and `in_b`==0 is not issued.
  - The FSM goes IDLE→DONE in one edge with `out_result`=0, `out_carry`=0, `out_err`=1.
  - `alu_*` registers still load.
  - `out_err` is 0 for every other op.
- **Not defined:** `out_err` is constant 0; mod-by-zero is issued normally and the ALU result is returned unchanged.

## Test plan
All scenarios use `ALU_LAT`=2.
1. **Reset:** `rst`=1 for 2 cycles with `in_valid`=1, opcode 000 → `in_ready`=0, no accept, all outputs 0; after release `in_ready`=1.
2. **Add with carry:** add 0xFFFFFFFF + 0x1 accepted at edge 0 → `out_valid` high from edge 2, `out_result`=0x00000000, `out_carry`=1, `busy`=1 until the handshake.
3. **Backpressure:** concat (101), a=0x12345678, b=0x0000ABCD, `out_ready`=0 for 5 cycles → `out_result`=0x000078CD held, `in_ready`=0, `alu_*` stable; then `out_ready`=1 → `out_valid` falls next edge.
4. **Back-to-back:** in DONE with `out_ready`=1 and `in_valid`=1, sub 10−3 → accepted at the same edge as the handshake; `out_result`=7, `out_carry`=0 two edges later.
5. **Mod by zero:** mod a=9, b=0 with the macro defined → `out_valid` after 1 edge, `out_result`=0, `out_err`=1. Without the macro → `out_valid` after 2 edges, `out_err`=0.
6. **Reset mid-op:** `rst` asserted at edge 1 of a mul 6×7 → `out_valid` never rises; state IDLE, `in_ready`=1 after release.
